alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Upstream command stage for alu_8bit.
- Accepts {SEL, A, B} operation requests over a valid/ready handshake and buffers them in a small FIFO.
- Issues one operation at a time to the registered ALU, waits the ALU latency, then captures ALU_OUT/CAR_OUT.
- Presents each result on a valid/ready result port and holds it until the consumer accepts it.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- ALU_LAT, 1, clock edges from ALU input change to ALU_OUT update; minimum 1.

Ports:
- CLK  in  1  clock; all registers update on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  FIFO not full.
- CMD_SEL  in  4  ALU opcode (same encoding as alu_8bit ALU_SEL).
- CMD_A  in  8  operand A.
- CMD_B  in  8  operand B.
- ALU_A  out  8  registered operand A to the ALU.
- ALU_B  out  8  registered operand B to the ALU.
- ALU_SEL  out  4  registered opcode to the ALU.
- ALU_OUT  in  16  ALU result.
- CAR_OUT  in  1  ALU carry.
- RES_VALID  out  1  result available.
- RES_READY  in  1  consumer accepts the result.
- RES_DATA  out  16  captured result.
- RES_CARRY  out  1  captured carry.
- RES_SEL  out  4  opcode that produced the result.
- BUSY  out  1  high when state != IDLE or FIFO non-empty.

Behaviour:
- Reset (async, RST=1):
  - All outputs 0; CMD_READY = 0 while RST is asserted, 1 after release.
  - FIFO emptied; state = IDLE.
  - An in-flight operation is discarded. RES_VALID drops immediately with no handshake.
- FIFO:
  - Push on a rising edge with CMD_VALID && CMD_READY. CMD_READY = !full and depends only on occupancy.
  - A full FIFO does not accept a push, even in a cycle where a pop occurs.
  - A push into an empty FIFO cannot be popped in the same edge; it issues on the following edge.
  - Pointers are log2(DEPTH)+1 bits; full/empty are derived from the MSB. Wrap-around is seamless.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE:
    - If the FIFO is non-empty: pop; load ALU_A/ALU_B/ALU_SEL and latch the opcode for RES_SEL; cnt <= ALU_LAT; go to WAIT.
  - WAIT:
    - If cnt != 0: cnt <= cnt-1.
    - If cnt == 0: RES_DATA <= ALU_OUT, RES_CARRY <= CAR_OUT, RES_VALID <= 1; go to HOLD.
  - HOLD:
    - RES_VALID, RES_DATA, RES_CARRY and RES_SEL are held stable while RES_READY = 0.
    - On an edge with RES_READY = 1: RES_VALID <= 0.
    - If the FIFO is non-empty on that edge, pop and issue in the same edge and go to WAIT; otherwise go to IDLE.
- Latency: RES_VALID rises ALU_LAT+1 edges after the issue (pop) edge. With ALU_LAT=1, that is 2 cycles.
- ALU_A/ALU_B/ALU_SEL change only on an issue edge and otherwise hold the last issued values.
- RES_DATA is passed through from the ALU unmodified (16 bits). No arithmetic is performed in this block.
- Capacity: DEPTH queued commands plus one in flight/held.

Optional Feature:
- Macro: SEQ_DIV0_BYPASS_EN.
- With the macro defined:
  - Extra port RES_ERR (out, 1).
  - An issue with opcode 3 or 4 and B == 0 does not drive the ALU: ALU_A/ALU_B/ALU_SEL keep their previous values.
  - The next edge loads RES_DATA = 16'hDEAD, RES_CARRY = 0, RES_ERR = 1, RES_VALID = 1; the FSM goes directly to HOLD (latency 1).
  - RES_ERR = 0 for all other results. RES_ERR resets to 0.
- Without the macro: there is no RES_ERR port, and every command goes through the ALU with the standard latency.

Test Plan:
- Reset: assert RST mid-WAIT -> RES_VALID, BUSY and ALU_* are 0 immediately; CMD_READY = 1 after release; no stale result is later presented.
- Add: CMD_SEL=0, A=30, B=22, RES_READY=1 -> 2 edges after the issue, RES_VALID=1, RES_DATA=52, RES_CARRY=0, RES_SEL=0. Next edge: RES_VALID=0.
- Back-pressure: RES_READY=0; push 6 commands (0xFF+0xFF add, then 5 others) back to back.
  - Expect: 1 in flight, 4 queued, CMD_READY=0 at the 6th.
  - Expect: RES_DATA=510, RES_CARRY=1, stable until RES_READY=1. The remaining results then appear in order.
- Stream: 8 multiply commands 0xF×0xC with RES_READY=1 -> all RES_DATA=180. Pointers wrap twice with no loss.
- Simultaneous: push into an empty FIFO while HOLD is handshaking -> the command issues on the following edge, not the same edge.
- SEQ_DIV0_BYPASS_EN defined: SEL=3, A=254, B=0 -> after 1 edge, RES_DATA=16'hDEAD, RES_ERR=1; ALU_SEL unchanged. SEL=3, A=254, B=127 -> RES_DATA=2, RES_ERR=0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Command stage in front of the registered alu_8bit. Operation requests
//   {SEL, A, B} are queued in a DEPTH-entry FIFO, issued one at a time to the
//   ALU, and the ALU result is captured after ALU_LAT edges. The result is
//   presented on a valid/ready port and held until the consumer accepts it.
//
//   Optional feature (macro SEQ_DIV0_BYPASS_EN): divide/modulo (opcode 3/4)
//   with B == 0 skips the ALU and returns 16'hDEAD with RES_ERR = 1 after a
//   single edge. Without the macro there is no RES_ERR port.
//
// Ports
//   CLK, RST                 clock, asynchronous active-high reset
//   CMD_VALID/CMD_READY      command handshake (READY = FIFO not full)
//   CMD_SEL, CMD_A, CMD_B    command opcode and operands
//   ALU_A, ALU_B, ALU_SEL    registered operands/opcode to the ALU
//   ALU_OUT, CAR_OUT         ALU result and carry
//   RES_VALID/RES_READY      result handshake
//   RES_DATA, RES_CARRY      captured result and carry
//   RES_SEL                  opcode that produced the result
//   RES_ERR                  bypassed divide-by-zero (macro builds only)
//   BUSY                     FSM not idle or FIFO non-empty
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [3:0]  CMD_SEL,
  input  logic [7:0]  CMD_A,
  input  logic [7:0]  CMD_B,
  output logic [7:0]  ALU_A,
  output logic [7:0]  ALU_B,
  output logic [3:0]  ALU_SEL,
  input  logic [15:0] ALU_OUT,
  input  logic        CAR_OUT,
  output logic        RES_VALID,
  input  logic        RES_READY,
  output logic [15:0] RES_DATA,
  output logic        RES_CARRY,
  output logic [3:0]  RES_SEL,
`ifdef SEQ_DIV0_BYPASS_EN
  output logic        RES_ERR,
`endif
  output logic        BUSY
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(ALU_LAT + 1);

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  // FIFO
  cmd_t          mem_q [DEPTH];
  cmd_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  // sequencer
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    alu_a_q, alu_a_d;
  logic [7:0]    alu_b_q, alu_b_d;
  logic [3:0]    alu_sel_q, alu_sel_d;
  logic          res_valid_q, res_valid_d;
  logic [15:0]   res_data_q, res_data_d;
  logic          res_carry_q, res_carry_d;
  logic [3:0]    res_sel_q, res_sel_d;
`ifdef SEQ_DIV0_BYPASS_EN
  logic          err_pend_q, err_pend_d;
  logic          res_err_q, res_err_d;
  logic          div0;
`endif

  logic empty, full, push, issue;
  cmd_t head;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // READY depends only on occupancy, so a pop in the same cycle never
  // opens a slot for a push into a full FIFO.
  assign CMD_READY = !full && !RST;
  assign push      = CMD_VALID && CMD_READY;

  // Issue uses the registered empty flag: a command pushed on this edge
  // into an empty FIFO can only issue on the next edge.
  assign issue = !empty &&
                 ((state_q == S_IDLE) || ((state_q == S_HOLD) && RES_READY));

`ifdef SEQ_DIV0_BYPASS_EN
  assign div0 = ((head.sel == 4'd3) || (head.sel == 4'd4)) && (head.b == 8'd0);
`endif

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_sel_d   = res_sel_q;
`ifdef SEQ_DIV0_BYPASS_EN
    err_pend_d  = err_pend_q;
    res_err_d   = res_err_q;
`endif

    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = '{sel: CMD_SEL, a: CMD_A, b: CMD_B};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (issue) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
`ifdef SEQ_DIV0_BYPASS_EN
          if (err_pend_q) begin
            res_data_d  = 16'hDEAD;
            res_carry_d = 1'b0;
            res_err_d   = 1'b1;
          end else begin
            res_data_d  = ALU_OUT;
            res_carry_d = CAR_OUT;
            res_err_d   = 1'b0;
          end
`else
          res_data_d  = ALU_OUT;
          res_carry_d = CAR_OUT;
`endif
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (RES_READY) begin
          res_valid_d = 1'b0;
`ifdef SEQ_DIV0_BYPASS_EN
          res_err_d   = 1'b0;
`endif
          state_d     = issue ? S_WAIT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Issue is shared by IDLE and the HOLD handshake edge.
    if (issue) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      res_sel_d = head.sel;
`ifdef SEQ_DIV0_BYPASS_EN
      if (div0) begin
        // ALU untouched; WAIT sees cnt == 0 and captures on the next edge.
        err_pend_d = 1'b1;
        cnt_d      = '0;
      end else begin
        err_pend_d = 1'b0;
        alu_a_d    = head.a;
        alu_b_d    = head.b;
        alu_sel_d  = head.sel;
        cnt_d      = CW'(ALU_LAT);
      end
`else
      alu_a_d   = head.a;
      alu_b_d   = head.b;
      alu_sel_d = head.sel;
      cnt_d     = CW'(ALU_LAT);
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_sel_q   <= '0;
`ifdef SEQ_DIV0_BYPASS_EN
      err_pend_q  <= 1'b0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_sel_q   <= res_sel_d;
`ifdef SEQ_DIV0_BYPASS_EN
      err_pend_q  <= err_pend_d;
      res_err_q   <= res_err_d;
`endif
    end
  end

  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_SEL   = alu_sel_q;
  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_data_q;
  assign RES_CARRY = res_carry_q;
  assign RES_SEL   = res_sel_q;
`ifdef SEQ_DIV0_BYPASS_EN
  assign RES_ERR   = res_err_q;
`endif
  assign BUSY      = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a one-cycle registered ALU stub, a queue of
// expected results filled at command acceptance, and a monitor that checks
// every accepted result plus hold stability under back-pressure.
module tb_alu_cmd_sequencer;
  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;

  logic        CLK = 1'b0;
  logic        RST, CMD_VALID, CMD_READY, RES_VALID, RES_READY, RES_CARRY, BUSY, CAR_OUT;
  logic [3:0]  CMD_SEL, ALU_SEL, RES_SEL;
  logic [7:0]  CMD_A, CMD_B, ALU_A, ALU_B;
  logic [15:0] ALU_OUT, RES_DATA;
`ifdef SEQ_DIV0_BYPASS_EN
  logic        RES_ERR;
`endif

  alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_SEL(CMD_SEL), .CMD_A(CMD_A), .CMD_B(CMD_B),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_SEL(ALU_SEL),
    .ALU_OUT(ALU_OUT), .CAR_OUT(CAR_OUT),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_DATA(RES_DATA), .RES_CARRY(RES_CARRY), .RES_SEL(RES_SEL),
`ifdef SEQ_DIV0_BYPASS_EN
    .RES_ERR(RES_ERR),
`endif
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] data;
    logic        carry;
    logic [3:0]  sel;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic rr_rand = 1'b0;

  // ALU behaviour: {carry, result}
  function automatic logic [16:0] alu_f(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    case (s)
      4'd0: begin t = {1'b0, a} + {1'b0, b}; return {t[8], 7'd0, t}; end
      4'd1: begin t = {1'b0, a} - {1'b0, b}; return {t[8], 7'd0, t}; end
      4'd2: return {1'b0, {8'd0, a} * {8'd0, b}};
      4'd3: return {1'b0, 8'd0, (b == 8'd0) ? 8'd0 : a / b};
      4'd4: return {1'b0, 8'd0, (b == 8'd0) ? 8'd0 : a % b};
      4'd5: return {1'b0, 8'd0, a & b};
      4'd6: return {1'b0, 8'd0, a | b};
      4'd7: return {1'b0, 8'd0, a ^ b};
      4'd8: return {1'b0, 8'd0, ~a};
      4'd9: return {1'b0, 7'd0, a, 1'b0};
      default: return 17'd0;
    endcase
  endfunction

  // Registered ALU stub (latency 1)
  always @(posedge CLK) {CAR_OUT, ALU_OUT} <= alu_f(ALU_SEL, ALU_A, ALU_B);

  function automatic exp_t ref_model(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [16:0] r;
    r       = alu_f(s, a, b);
    e.data  = r[15:0];
    e.carry = r[16];
    e.sel   = s;
    e.err   = 1'b0;
`ifdef SEQ_DIV0_BYPASS_EN
    if ((s == 4'd3 || s == 4'd4) && b == 8'd0) begin
      e.data  = 16'hDEAD;
      e.carry = 1'b0;
    e.err   = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive a command; called just after a rising edge, returns just after
  // the accepting edge.
  task automatic push(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    bit done = 1'b0;
    CMD_VALID = 1'b1; CMD_SEL = s; CMD_A = a; CMD_B = b;
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK);
      if (CMD_READY) begin
        exp_q.push_back(ref_model(s, a, b));
        done = 1'b1;
        break;
      end
    end
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL push_timeout: CMD_READY stayed 0, expected 1");
    end
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && !BUSY && !RES_VALID) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
    @(posedge CLK); #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      n++;
      if (RES_VALID) break;
    end
  endtask

  // Monitor: compare on each handshake, check stability while held.
  initial begin
    logic        holding;
    logic [20:0] held;
    exp_t        e;
    holding = 1'b0;
    held    = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        holding = 1'b0;
      end else if (RES_VALID) begin
        if (holding) chk("hold_stable", {11'd0, RES_DATA, RES_CARRY, RES_SEL}, {11'd0, held});
        if (RES_READY) begin
          holding = 1'b0;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: got data 0x%0h, expected no result", RES_DATA);
          end else begin
            e = exp_q.pop_front();
            chk("res_data",  RES_DATA,  e.data);
            chk("res_carry", RES_CARRY, e.carry);
            chk("res_sel",   RES_SEL,   e.sel);
`ifdef SEQ_DIV0_BYPASS_EN
            chk("res_err",   RES_ERR,   e.err);
`endif
          end
        end else begin
          holding = 1'b1;
          held    = {RES_DATA, RES_CARRY, RES_SEL};
        end
      end else begin
        if (holding) chk("valid_dropped_unaccepted", RES_VALID, 1);
        holding = 1'b0;
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    if (rr_rand) RES_READY = ($urandom_range(0, 2) != 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RST = 1'b1; CMD_VALID = 1'b0; CMD_SEL = '0; CMD_A = '0; CMD_B = '0; RES_READY = 1'b0;
    #2;
    chk("rst_res_valid", RES_VALID, 0);
    chk("rst_cmd_ready", CMD_READY, 0);
    chk("rst_busy",      BUSY,      0);
    chk("rst_alu",       {ALU_A, ALU_B, ALU_SEL}, 0);
    chk("rst_res",       {RES_DATA, RES_CARRY, RES_SEL}, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_cmd_ready", CMD_READY, 1);
    chk("post_rst_busy",      BUSY,      0);
    @(posedge CLK); #1;

    // Add with latency check: push edge, issue next edge, valid 2 edges later
    RES_READY = 1'b1;
    push(4'd0, 8'd30, 8'd22);
    wait_valid(n);
    chk("add_latency", n, 4);
    chk("add_data", RES_DATA, 52);
    @(negedge CLK);
    chk("add_valid_drop", RES_VALID, 0);
    @(posedge CLK); #1;

    // Reset while in WAIT
    push(4'd2, 8'd7, 8'd9);
    @(negedge CLK);
    @(negedge CLK);
    chk("wait_alu_a", ALU_A, 7);
    #2 RST = 1'b1;
    #1;
    chk("midrst_res_valid", RES_VALID, 0);
    chk("midrst_busy",      BUSY,      0);
    chk("midrst_alu",       {ALU_A, ALU_B, ALU_SEL}, 0);
    chk("midrst_cmd_ready", CMD_READY, 0);
    exp_q.delete();
    @(posedge CLK); @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    chk("midrst_release_ready", CMD_READY, 1);
    repeat (6) @(negedge CLK);
    chk("no_stale_result", RES_VALID, 0);
    @(posedge CLK); #1;

    // Back-pressure: 1 in flight + 4 queued, 6th refused until drain
    RES_READY = 1'b0;
    push(4'd0, 8'hFF, 8'hFF);
    push(4'd1, 8'h10, 8'h20);
    push(4'd5, 8'hF0, 8'h3C);
    push(4'd6, 8'h0F, 8'h30);
    push(4'd9, 8'h81, 8'h00);
    @(negedge CLK);
    chk("bp_cmd_ready_full", CMD_READY, 0);
    chk("bp_busy",           BUSY,      1);
    chk("bp_valid",          RES_VALID, 1);
    chk("bp_data",           RES_DATA,  510);
    chk("bp_carry",          RES_CARRY, 1);
    fork
      push(4'd7, 8'h3C, 8'h5A);
      begin repeat (5) @(posedge CLK); #1 RES_READY = 1'b1; end
    join
    wait_drain();

    // Stream of multiplies; pointers wrap twice
    RES_READY = 1'b1;
    for (int i = 0; i < 8; i++) push(4'd2, 8'h0F, 8'h0C);
    wait_drain();

    // Push into empty FIFO on the HOLD handshake edge
    RES_READY = 1'b0;
    push(4'd0, 8'd1, 8'd2);
    wait_valid(n);
    chk("sim_hold_valid", RES_VALID, 1);
    @(posedge CLK); #1;
    RES_READY = 1'b1;
    push(4'd5, 8'hAA, 8'h0F);
    @(negedge CLK);
    chk("sim_not_issued_a",   ALU_A,   1);
    chk("sim_not_issued_sel", ALU_SEL, 0);
    chk("sim_busy",           BUSY,    1);
    @(negedge CLK);
    chk("sim_issued_a",   ALU_A,   8'hAA);
    chk("sim_issued_sel", ALU_SEL, 5);
    wait_drain();

`ifdef SEQ_DIV0_BYPASS_EN
    push(4'd0, 8'd3, 8'd4);
    wait_drain();
    push(4'd3, 8'd254, 8'd0);
    wait_valid(n);
    chk("div0_latency", n, 3);
    chk("div0_data",    RES_DATA, 16'hDEAD);
    chk("div0_err",     RES_ERR,  1);
    chk("div0_alu_sel", ALU_SEL,  0);
    chk("div0_alu_a",   ALU_A,    3);
    wait_drain();
    push(4'd3, 8'd254, 8'd127);
    wait_valid(n);
    chk("div_latency", n, 4);
    chk("div_data",    RES_DATA, 2);
    chk("div_err",     RES_ERR,  0);
    wait_drain();
`endif

    // Random commands with random back-pressure
    rr_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] rb;
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      push(4'($urandom_range(0, 9)), 8'($urandom), rb);
    end
    rr_rand = 1'b0;
    @(posedge CLK); #2 RES_READY = 1'b1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
